alu_share_arbiter: RTL and testbench

- Shares one combinational `ALU` instance between two requesters, e.g. the execute-stage datapath (port 0) and a multi-cycle helper unit (port 1).
- Arbitrates valid/ready requests and drives the shared ALU inputs for the granted port.
- Captures Res/Zero/lt in a one-entry registered response slot, tagged with the requester id.
- Response is returned on a single valid/ready response channel.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/ALU.sv | 35 +++
 rtl/alu_share_rr_grant.sv | 37 +++
 rtl/alu_share_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter.
// Holds the fixed ALU geometry, op-code constants and the registered
// response-slot payload carried from the ALU to the response channel.
package alu_pkg;

  localparam int unsigned ALU_W      = 32;
  localparam int unsigned ALU_CTRL_W = 3;

  // ALU op codes; 3'b110 is unassigned and flagged as illegal.
  typedef enum logic [ALU_CTRL_W-1:0] {
    OP_SUM     = 3'b000,
    OP_SUB     = 3'b001,
    OP_AND     = 3'b010,
    OP_OR      = 3'b011,
    OP_SRCB    = 3'b100,
    OP_LT      = 3'b101,
    OP_ILLEGAL = 3'b110,
    OP_XOR     = 3'b111
  } alu_op_e;

  // One response-slot entry.
  typedef struct packed {
    logic             id;
    logic [ALU_W-1:0] res;
    logic             zero;
    logic             lt;
    logic             illegal;
  } rsp_slot_t;

  // True when the op code is the unassigned encoding.
  function automatic logic is_illegal_op(input logic [ALU_CTRL_W-1:0] op);
    return op == OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/ALU.sv
// Existing 32-bit combinational ALU shared by the arbiter.
// Ports:
//   A, B        32-bit operands (signed for the lt comparison)
//   ALUControl  3-bit op code (SUM, SUB, AND, OR, SRCB, LT, XOR)
//   Res         32-bit result, wraps mod 2^32
//   Zero        Res == 0
//   lt          signed A < B, independent of the op code
module ALU (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUControl,
  output logic [31:0] Res,
  output logic        Zero,
  output logic        lt
);

  assign lt   = $signed(A) < $signed(B);
  assign Zero = (Res == 32'd0);

  // Result select.
  always_comb begin
    Res = 32'd0;
    case (ALUControl)
      3'b000:  Res = A + B;
      3'b001:  Res = A - B;
      3'b010:  Res = A & B;
      3'b011:  Res = A | B;
      3'b100:  Res = B;
      3'b101:  Res = {31'd0, lt};
      3'b111:  Res = A ^ B;
      default: Res = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_share_rr_grant.sv
// Two-port grant logic for the shared ALU.
// Build option: ALU_SHARE_RR_EN selects round-robin on conflict (the port
// that was not granted last wins); without it port 0 always wins.
// Ports:
//   valid0, valid1  request valids
//   can_accept      response slot can take a result this cycle
//   last_grant      port granted by the previous accept (round-robin only)
//   grant_c         one-hot grant, bit N = port N, combinational
module alu_share_rr_grant (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       can_accept,
`ifdef ALU_SHARE_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant_c
);

  // Single requester wins outright; conflicts resolved by the build option.
  always_comb begin
    grant_c = 2'b00;
    if (can_accept) begin
      if (valid0 && valid1) begin
`ifdef ALU_SHARE_RR_EN
        grant_c = last_grant ? 2'b01 : 2'b10;
`else
        grant_c = 2'b01;
`endif
      end else if (valid0) begin
        grant_c = 2'b01;
      end else if (valid1) begin
        grant_c = 2'b10;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters and returns
// results through a one-entry registered response slot tagged with the id.
// Build option: ALU_SHARE_RR_EN (round-robin on conflict, else port 0 priority).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   reqN_valid/ready/a/b/ctrl         request channel of port N (N = 0, 1)
//   rsp_valid/ready                   response handshake
//   rsp_id/res/zero/lt/illegal        registered response payload
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_res,
  output logic              rsp_zero,
  output logic              rsp_lt,
  output logic              rsp_illegal
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  slot_state_e          state_q, state_d;
  rsp_slot_t            slot_q, slot_d;
  logic                 load_c;
  logic                 can_accept_c;
  logic [1:0]           grant_c;
  logic                 accept_c;
  logic [ALU_W-1:0]     alu_a_c, alu_b_c, alu_res_c;
  logic [ALU_CTRL_W-1:0] alu_ctrl_c;
  logic                 alu_zero_c, alu_lt_c;

  // Reset blocks accepts so no ready is raised during the reset cycle.
  assign can_accept_c = ~rst & ((state_q == S_EMPTY) | rsp_ready);

`ifdef ALU_SHARE_RR_EN
  logic last_grant_q;

  // Remembers the last accepted port; starts at 1 so port 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (accept_c) begin
      last_grant_q <= grant_c[1];
    end
  end
`endif

  alu_share_rr_grant u_grant (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .can_accept (can_accept_c),
`ifdef ALU_SHARE_RR_EN
    .last_grant (last_grant_q),
`endif
    .grant_c    (grant_c)
  );

  assign accept_c   = |grant_c;
  assign req0_ready = grant_c[0];
  assign req1_ready = grant_c[1];

  // Route the granted port to the ALU; idle drives a zero SUM.
  always_comb begin
    alu_a_c    = '0;
    alu_b_c    = '0;
    alu_ctrl_c = OP_SUM;
    if (grant_c[0]) begin
      alu_a_c    = ALU_W'(req0_a);
      alu_b_c    = ALU_W'(req0_b);
      alu_ctrl_c = ALU_CTRL_W'(req0_ctrl);
    end else if (grant_c[1]) begin
      alu_a_c    = ALU_W'(req1_a);
      alu_b_c    = ALU_W'(req1_b);
      alu_ctrl_c = ALU_CTRL_W'(req1_ctrl);
    end
  end

  ALU u_alu (
    .A          (alu_a_c),
    .B          (alu_b_c),
    .ALUControl (alu_ctrl_c),
    .Res        (alu_res_c),
    .Zero       (alu_zero_c),
    .lt         (alu_lt_c)
  );

  // Slot payload; the illegal op forces a zero result with Zero set.
  always_comb begin
    slot_d.id      = grant_c[1];
    slot_d.illegal = is_illegal_op(alu_ctrl_c);
    slot_d.res     = slot_d.illegal ? '0 : alu_res_c;
    slot_d.zero    = slot_d.illegal ? 1'b1 : alu_zero_c;
    slot_d.lt      = alu_lt_c;
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot next state; a drain with a simultaneous accept stays FULL.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept_c) begin
          state_d = S_FULL;
          load_c  = 1'b1;
        end
      end
      S_FULL: begin
        if (accept_c) begin
          load_c = 1'b1;
        end else if (rsp_ready) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Payload register; held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else if (load_c) begin
      slot_q <= slot_d;
    end
  end

  assign rsp_valid   = (state_q == S_FULL);
  assign rsp_id      = slot_q.id;
  assign rsp_res     = WIDTH'(slot_q.res);
  assign rsp_zero    = slot_q.zero;
  assign rsp_lt      = slot_q.lt;
  assign rsp_illegal = slot_q.illegal;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a response scoreboard.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_lt, rsp_illegal;
  logic [31:0] rsp_res;

  int checks = 0;
  int errors = 0;

  rsp_slot_t exp_q[$];
  logic      m_known = 1'b0;
`ifdef ALU_SHARE_RR_EN
  logic      m_last = 1'b1;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ctrl   (req0_ctrl),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ctrl   (req1_ctrl),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_res     (rsp_res),
    .rsp_zero    (rsp_zero),
    .rsp_lt      (rsp_lt),
    .rsp_illegal (rsp_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU behaviour including the illegal-op override.
  function automatic rsp_slot_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] ctrl, input logic id);
    rsp_slot_t r;
    r.id      = id;
    r.lt      = $signed(a) < $signed(b);
    r.illegal = 1'b0;
    case (ctrl)
      3'b000:  r.res = a + b;
      3'b001:  r.res = a - b;
      3'b010:  r.res = a & b;
      3'b011:  r.res = a | b;
      3'b100:  r.res = b;
      3'b101:  r.res = {31'd0, r.lt};
      3'b111:  r.res = a ^ b;
      default: begin r.res = 32'd0; r.illegal = 1'b1; end
    endcase
    r.zero = (r.res == 32'd0);
    return r;
  endfunction

  function automatic logic [1:0] model_grant(input logic v0, input logic v1, input logic ca);
    if (!ca) return 2'b00;
    if (v0 && v1) begin
`ifdef ALU_SHARE_RR_EN
      return m_last ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
  endfunction

  // One clock: check readys and the slot at negedge, advance the model, return #1 after posedge.
  task automatic cycle();
    logic       ca;
    logic [1:0] g;
    @(negedge clk);
    ca = !rst && (exp_q.size() == 0 || rsp_ready);
    g  = model_grant(req0_valid, req1_valid, ca);
    check("req0_ready", 32'(req0_ready), 32'(g[0]));
    check("req1_ready", 32'(req1_ready), 32'(g[1]));
    if (m_known) begin
      check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("rsp_id",      32'(rsp_id),      32'(exp_q[0].id));
        check("rsp_res",     rsp_res,          exp_q[0].res);
        check("rsp_zero",    32'(rsp_zero),    32'(exp_q[0].zero));
        check("rsp_lt",      32'(rsp_lt),      32'(exp_q[0].lt));
        check("rsp_illegal", 32'(rsp_illegal), 32'(exp_q[0].illegal));
      end
    end
    if (rst) begin
      exp_q.delete();
      m_known = 1'b1;
`ifdef ALU_SHARE_RR_EN
      m_last = 1'b1;
`endif
    end else begin
      if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
      if (g[0]) exp_q.push_back(ref_alu(req0_a, req0_b, req0_ctrl, 1'b0));
      else if (g[1]) exp_q.push_back(ref_alu(req1_a, req1_b, req1_ctrl, 1'b1));
`ifdef ALU_SHARE_RR_EN
      if (g != 2'b00) m_last = g[1];
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] conflict_ids;
`ifdef ALU_SHARE_RR_EN
    conflict_ids = 4'b1010;   // bit k = id of k-th accept: 0,1,0,1
`else
    conflict_ids = 4'b0000;
`endif
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = OP_SUM;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = OP_SUM;

    // Reset with both requesters valid.
    cycle();
    cycle();
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_res",   rsp_res,        32'd0);
    check("reset rsp_id",    32'(rsp_id),    32'd0);
    check("reset flags",     32'({rsp_zero, rsp_lt, rsp_illegal}), 32'd0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;

    // Single SUB on port 0.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = OP_SUB;
    cycle();
    req0_valid = 1'b0;
    check("sub valid", 32'(rsp_valid), 32'd1);
    check("sub res",   rsp_res,        32'hFFFF_FFFE);
    check("sub lt",    32'(rsp_lt),    32'd1);
    check("sub zero",  32'(rsp_zero),  32'd0);

    // Illegal op on port 1.
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd9; req1_ctrl = OP_ILLEGAL;
    cycle();
    req1_valid = 1'b0;
    check("illegal flag", 32'(rsp_illegal), 32'd1);
    check("illegal res",  rsp_res,          32'd0);
    check("illegal zero", 32'(rsp_zero),    32'd1);
    check("illegal id",   32'(rsp_id),      32'd1);

    // Conflict: both ports valid for four accepts.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = OP_OR;
    req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd9; req1_ctrl = OP_SRCB;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("conflict id", 32'(rsp_id), 32'(conflict_ids[k]));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Signed wrap and the LT op.
    req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_ctrl = OP_SUM;
    cycle();
    req0_valid = 1'b0;
    check("wrap res", rsp_res, 32'h8000_0000);
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_ctrl = OP_LT;
    cycle();
    req1_valid = 1'b0;
    check("lt res", rsp_res, 32'd1);

    // Backpressure: AND on port 1, then hold while port 0 waits with XOR.
    req1_valid = 1'b1; req1_a = 32'h0000_F0F0; req1_b = 32'h0000_0FF0; req1_ctrl = OP_AND;
    cycle();
    req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h0000_FF00; req0_b = 32'h0000_0FF0; req0_ctrl = OP_XOR;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall res", rsp_res, 32'h0000_00F0);
    end
    rsp_ready = 1'b1;
    cycle();
    req0_valid = 1'b0;
    check("refill valid", 32'(rsp_valid), 32'd1);
    check("refill res",   rsp_res,        32'h0000_F0F0);
    check("refill id",    32'(rsp_id),    32'd0);
    cycle();

    // Reset while a response is pending.
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_ctrl = OP_SUM;
    cycle();
    rsp_ready = 1'b0; rst = 1'b1; req1_valid = 1'b1;
    cycle();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    check("mid reset valid", 32'(rsp_valid), 32'd0);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
